map_ss_seq: RTL

- Save-state sequencer for mapper register windows.
- Walks the mapper's byte-wide save-state window (ss_addr 0..NREG-1; index 127 carries map_idx) and streams bytes out on save, or streams bytes in and writes them on load.
- Owns ss_act/ss_we/ss_addr/ss_dat for the mapper. Mapper registers latch on the falling edge of m2, so every load write is held across a detected m2 fall.

---
 rtl/map_ss_seq_pkg.sv | 34 +++
 rtl/map_ss_seq_if.sv | 30 +++
 rtl/map_m2_edge.sv | 51 +++++
 rtl/map_ss_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/map_ss_seq_pkg.sv
// Shared definitions for the mapper save-state sequencer: state encoding,
// window geometry and the index that carries the mapper id.
package map_ss_seq_pkg;

    // Width of the save-state window address and data bytes.
    localparam int SS_AW = 8;
    localparam int SS_DW = 8;

    // Window index whose load byte must match the expected mapper index.
    localparam logic [SS_AW-1:0] SS_IDX_MAP = 8'd127;

    // Clocks between an m2 pin edge and its m2_fall pulse reaching the FSM
    // (two synchronizer flops); write strobes wait this long before trusting
    // a detected fall as belonging to the current write.
    localparam int SYNC_LAT = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        L_IN   = 3'd4,
        L_WR   = 3'd5,
        FIN    = 3'd6,
        ABORT  = 3'd7
    } seq_state_t;

    // States in which the sequencer owns the mapper (ss_act/busy high).
    function automatic logic st_active(input seq_state_t s);
        return (s == ARM) || (s == S_WAIT) || (s == S_OUT) ||
               (s == L_IN) || (s == L_WR);
    endfunction

endpackage

// File: rtl/map_ss_seq_if.sv
// Save-state bus to the mapper plus the byte streams in and out of the
// sequencer. master = sequencer side, slave = mapper / stream endpoint side.
interface map_ss_seq_if;
    import map_ss_seq_pkg::*;

    logic             ss_act;
    logic             ss_we;
    logic [SS_AW-1:0] ss_addr;
    logic [SS_DW-1:0] ss_dat;
    logic [SS_DW-1:0] ss_rdat;

    logic [SS_DW-1:0] out_dat;
    logic             out_vld;
    logic             out_rdy;

    logic [SS_DW-1:0] in_dat;
    logic             in_vld;
    logic             in_rdy;

    modport master (
        output ss_act, ss_we, ss_addr, ss_dat, out_dat, out_vld, in_rdy,
        input  ss_rdat, out_rdy, in_dat, in_vld
    );

    modport slave (
        input  ss_act, ss_we, ss_addr, ss_dat, out_dat, out_vld, in_rdy,
        output ss_rdat, out_rdy, in_dat, in_vld
    );

endinterface

// File: rtl/map_m2_edge.sv
// m2 synchronizer, falling-edge pulse and "no m2 activity" timeout.
// The timeout counter only runs while en is high and restarts on every
// detected fall, so the caller sees timeout after M2_TO quiet clocks.
module map_m2_edge #(
    parameter int M2_TO = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic m2,
    input  logic en,
    output logic fall,
    output logic timeout
);

    localparam int             CW      = $clog2(M2_TO + 1);
    localparam logic [CW-1:0]  CNT_END = CW'(M2_TO);

    logic          m2_s1;
    logic          m2_s2;
    logic          m2_s3;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer plus one history flop for the edge compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_s1 <= 1'b0;
            m2_s2 <= 1'b0;
            m2_s3 <= 1'b0;
        end else begin
            m2_s1 <= m2;
            m2_s2 <= m2_s1;
            m2_s3 <= m2_s2;
        end
    end

    assign fall = m2_s3 & ~m2_s2;

    // Quiet-time counter: cleared by a fall or when disabled, saturates at M2_TO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || fall) begin
            cnt <= '0;
        end else if (cnt != CNT_END) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign timeout = en && (cnt == CNT_END);

endmodule

// File: rtl/map_ss_seq.sv
// Save-state sequencer for a mapper register window.
// Save: freeze mapper, read each window byte and push it on the out stream.
// Load: freeze mapper, take each byte from the in stream and write it,
// holding the write strobe across an m2 fall so the mapper latches it.
//
// state  | meaning
// IDLE   | waiting for cmd_req
// ARM    | ss_act raised, waiting GUARD m2 falls for the mapper to freeze
// S_WAIT | save: waiting for ss_rdat to settle after an address change
// S_OUT  | save: byte presented on out_dat, waiting for out_rdy
// L_IN   | load: in_rdy high, waiting for a stream byte
// L_WR   | load: ss_we high, waiting for a qualified m2 fall plus one hold clk
// FIN    | one-cycle done pulse
// ABORT  | error exit: drop everything, no done
module map_ss_seq
    import map_ss_seq_pkg::*;
#(
    parameter int NREG   = 128,
    parameter int RD_LAT = 2,
    parameter int GUARD  = 2,
    parameter int M2_TO  = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m2,
    input  logic             cmd_req,
    input  logic             cmd_load,
    input  logic [SS_DW-1:0] map_idx,
    output logic             busy,
    output logic             done,
    output logic             err,
    map_ss_seq_if.master     ssb
);

    localparam logic [SS_AW-1:0] LAST       = SS_AW'(NREG - 1);
    localparam bit               CHK_IDX    = (NREG > 127);
    localparam logic [2:0]       LAT_END    = 3'(RD_LAT);
    localparam int               GW         = $clog2(GUARD + 1);
    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD - 1);
    localparam logic [1:0]       AGE_OK     = 2'(SYNC_LAT);

    seq_state_t       state;
    seq_state_t       state_nxt;

    logic             load_q;
    logic [SS_AW-1:0] addr_q;
    logic [SS_DW-1:0] dat_q;
    logic [SS_DW-1:0] odat_q;
    logic             err_q;
    logic [2:0]       lat_cnt;
    logic [1:0]       we_age;
    logic [GW-1:0]    guard_cnt;
    logic             hold_q;

    logic             m2_fall;
    logic             m2_tout;
    logic             tout_en;
    logic             fall_ok;

    logic             accept;
    logic             addr_clr;
    logic             addr_inc;
    logic             cap_out;
    logic             cap_in;
    logic             set_err;

    logic             busy_q, act_q, we_q, ovld_q, irdy_q, done_q;
    logic             busy_nxt, act_nxt, we_nxt, ovld_nxt, irdy_nxt, done_nxt;

    assign tout_en = (state == ARM) || (state == L_WR);

    map_m2_edge #(
        .M2_TO(M2_TO)
    ) u_m2_edge (
        .clk    (clk),
        .rst    (rst),
        .m2     (m2),
        .en     (tout_en),
        .fall   (m2_fall),
        .timeout(m2_tout)
    );

    // A detected fall is two clocks old; only trust it once ss_we has been
    // high that long, otherwise the pin edge may predate the write strobe.
    assign fall_ok = m2_fall && (we_age == AGE_OK);

    // State and registered outputs; outputs are decoded from the next state
    // so the mapper sees glitch-free strobes that still reset asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            act_q  <= 1'b0;
            we_q   <= 1'b0;
            ovld_q <= 1'b0;
            irdy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            act_q  <= act_nxt;
            we_q   <= we_nxt;
            ovld_q <= ovld_nxt;
            irdy_q <= irdy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        addr_clr  = 1'b0;
        addr_inc  = 1'b0;
        cap_out   = 1'b0;
        cap_in    = 1'b0;
        set_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_req) begin
                    accept    = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (m2_tout) begin
                    set_err   = 1'b1;
                    state_nxt = ABORT;
                end else if (m2_fall && (guard_cnt == GUARD_LAST)) begin
                    addr_clr  = 1'b1;
                    state_nxt = load_q ? L_IN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LAT_END) begin
                    cap_out   = 1'b1;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (ssb.out_rdy) begin
                    if (addr_q == LAST) begin
                        state_nxt = FIN;
                    end else begin
                        addr_inc  = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
            end
            L_IN: begin
                if (ssb.in_vld) begin
                    if (CHK_IDX && (addr_q == SS_IDX_MAP) && (ssb.in_dat != map_idx)) begin
                        set_err   = 1'b1;
                        state_nxt = ABORT;
                    end else begin
                        cap_in    = 1'b1;
                        state_nxt = L_WR;
                    end
                end
            end
            L_WR: begin
                if (m2_tout) begin
                    set_err   = 1'b1;
                    state_nxt = ABORT;
                end else if (hold_q) begin
                    if (addr_q == LAST) begin
                        state_nxt = FIN;
                    end else begin
                        addr_inc  = 1'b1;
                        state_nxt = L_IN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the state being entered.
    always_comb begin
        busy_nxt = st_active(state_nxt);
        act_nxt  = st_active(state_nxt);
        we_nxt   = (state_nxt == L_WR);
        ovld_nxt = (state_nxt == S_OUT);
        irdy_nxt = (state_nxt == L_IN);
        done_nxt = (state_nxt == FIN);
    end

    // Address, data capture, sticky error and per-state counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q    <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            odat_q    <= '0;
            err_q     <= 1'b0;
            lat_cnt   <= '0;
            we_age    <= '0;
            guard_cnt <= '0;
            hold_q    <= 1'b0;
        end else begin
            if (accept) begin
                load_q <= cmd_load;
                err_q  <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (accept || addr_clr) begin
                addr_q <= '0;
            end else if (addr_inc) begin
                addr_q <= addr_q + SS_AW'(1);
            end
            if (cap_in) begin
                dat_q <= ssb.in_dat;
            end
            if (cap_out) begin
                odat_q <= ssb.ss_rdat;
            end
            lat_cnt <= (state == S_WAIT) ? lat_cnt + 3'd1 : 3'd0;
            if (state != L_WR) begin
                we_age <= 2'd0;
            end else if (we_age != AGE_OK) begin
                we_age <= we_age + 2'd1;
            end
            if (state != ARM) begin
                guard_cnt <= '0;
            end else if (m2_fall) begin
                guard_cnt <= guard_cnt + GW'(1);
            end
            hold_q <= (state == L_WR) && (hold_q || fall_ok);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ssb.ss_act  = act_q;
    assign ssb.ss_we   = we_q;
    assign ssb.ss_addr = addr_q;
    assign ssb.ss_dat  = dat_q;
    assign ssb.out_dat = odat_q;
    assign ssb.out_vld = ovld_q;
    assign ssb.in_rdy  = irdy_q;

endmodule
